// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CMD,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DATA
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access, one transaction
// at a time, data-first with a bounded-starvation guarantee for fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_cmd_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_cmd_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_reg, state_next;
  arb_owner_t       owner_reg, owner_next;
  logic             we_reg, we_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             drop_reg, drop_next;
  logic [31:0]      if_rdata_reg, if_rdata_next;
  logic [31:0]      d_rdata_reg, d_rdata_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_IF;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      starve_cnt_reg <= '0;
      drop_reg       <= 1'b0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      starve_cnt_reg <= starve_cnt_next;
      drop_reg       <= drop_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    starve_cnt_next = starve_cnt_reg;
    drop_next       = drop_reg;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;

    case (state_reg)
      ARB_IDLE: begin
        drop_next = 1'b0;
        if (!if_req) starve_cnt_next = '0;
        if (if_req && starve_cnt_reg == LIMIT) begin
          state_next      = ARB_CMD;
          owner_next      = OWN_IF;
          we_next         = 1'b0;
          addr_next       = if_addr;
          wdata_next      = '0;
          starve_cnt_next = '0;
        end else if (d_req) begin
          state_next = ARB_CMD;
          owner_next = OWN_DATA;
          we_next    = d_we;
          addr_next  = d_addr;
          wdata_next = d_wdata;
          // Reaching here with if_req set implies the counter is still below the limit.
          starve_cnt_next = if_req ? starve_cnt_reg + 1'b1 : '0;
        end else if (if_req) begin
          state_next      = ARB_CMD;
          owner_next      = OWN_IF;
          we_next         = 1'b0;
          addr_next       = if_addr;
          wdata_next      = '0;
          starve_cnt_next = '0;
        end
      end

      ARB_CMD: begin
        if (owner_reg == OWN_IF && flush) begin
          // An accepted command must still be drained; an unaccepted one is simply withdrawn.
          if (mem_cmd_ready) begin
            drop_next  = 1'b1;
            state_next = ARB_WAIT;
          end else begin
            state_next = ARB_IDLE;
          end
        end else if (mem_cmd_ready) begin
          state_next = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        if (owner_reg == OWN_IF && flush) drop_next = 1'b1;
        if (mem_resp_valid) begin
          state_next = ARB_RESP;
          if (owner_reg == OWN_DATA) begin
            d_rdata_next = mem_rdata;
          end else if (!drop_next) begin
            if_rdata_next = mem_rdata;
          end
        end
      end

      ARB_RESP: begin
        state_next = ARB_IDLE;
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign mem_cmd_valid = (state_reg == ARB_CMD);
  assign mem_we        = mem_cmd_valid & we_reg;
  assign mem_addr      = mem_cmd_valid ? addr_reg : '0;
  assign mem_wdata     = mem_cmd_valid ? wdata_reg : '0;

  assign if_rvalid = (state_reg == ARB_RESP) && (owner_reg == OWN_IF) && !drop_reg;
  assign d_done    = (state_reg == ARB_RESP) && (owner_reg == OWN_DATA);
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  assign if_stall = if_req & ~if_rvalid;
  assign d_stall  = d_req & ~d_done;

endmodule
